ga_generation_controller: RTL and testbench

- Top-level sequencer for the genetic-algorithm datapath; owns generation flow, not chromosome data.
- Runs population init, per-individual fitness evaluation and per-individual breeding (select/crossover/mutate) through three req/ack handshakes.
- Tracks the best fitness and its index, and stops on target fitness or generation limit.
- Sits between the top-level Genetic_Algorithm wrapper (START/DONE) and the fitness and breeding units.

---
 rtl/ga_generation_controller_pkg.sv | 28 ++
 rtl/ga_generation_controller_if.sv | 42 ++++
 rtl/ga_generation_controller_req_iter.sv | 33 +++
 rtl/ga_generation_controller.sv | 117 +++++++++++
 tb/tb_ga_generation_controller.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ga_generation_controller_pkg.sv
// Shared types and defaults for the genetic-algorithm generation controller.
package ga_pkg;
  localparam int GA_SIZE      = 8;    // chromosome/coordinate width
  localparam int GA_MAX_COORD = 180;
  localparam int GA_FIT_W     = 16;
  localparam int GA_POP_SIZE  = 8;
  localparam int GA_MAX_GEN   = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_EVAL   = 3'd2,
    S_CHECK  = 3'd3,
    S_BREED  = 3'd4,
    S_FINISH = 3'd5
  } ga_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int gen_width(input int g);
    return (g > 0) ? $clog2(g + 1) : 1;
  endfunction

  localparam int GA_IDX_W = idx_width(GA_POP_SIZE);
  localparam int GA_GEN_W = gen_width(GA_MAX_GEN);
endpackage

// File: rtl/ga_generation_controller_if.sv
// Controller-facing bundle: START/DONE side plus the init, fitness and breed req/ack links.
interface ga_generation_controller_if
  import ga_pkg::*;
#(
  parameter int POP_SIZE = GA_POP_SIZE,
  parameter int MAX_GEN  = GA_MAX_GEN,
  parameter int FIT_W    = GA_FIT_W
);
  localparam int IDX_W = idx_width(POP_SIZE);
  localparam int GEN_W = gen_width(MAX_GEN);

  logic             start;
  logic [FIT_W-1:0] target_fit;
  // req/ack: req is registered, a transfer happens on every edge with req && ack,
  // and ack seen while req is low has no effect.
  logic             init_req;
  logic             init_ack;
  logic             fit_req;
  logic [IDX_W-1:0] fit_idx;
  logic             fit_ack;
  logic [FIT_W-1:0] fit_value;
  logic             breed_req;
  logic [IDX_W-1:0] breed_idx;
  logic             breed_ack;
  logic [GEN_W-1:0] gen_count;
  logic [FIT_W-1:0] best_fit;
  logic [IDX_W-1:0] best_idx;
  logic             busy;
  logic             done;

  modport master (
    input  start, target_fit, init_ack, fit_ack, fit_value, breed_ack,
    output init_req, fit_req, fit_idx, breed_req, breed_idx,
           gen_count, best_fit, best_idx, busy, done
  );

  modport slave (
    output start, target_fit, init_ack, fit_ack, fit_value, breed_ack,
    input  init_req, fit_req, fit_idx, breed_req, breed_idx,
           gen_count, best_fit, best_idx, busy, done
  );
endinterface

// File: rtl/ga_generation_controller_req_iter.sv
// Issues COUNT back-to-back requests with an index; a start pulse restarts at index 0.
module ga_req_iter #(
  parameter int COUNT = 1,
  parameter int IDX_W = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             ack,
  output logic             req,
  output logic [IDX_W-1:0] idx,
  output logic             last,
  output logic             done
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COUNT - 1);

  assign last = (idx == LAST_IDX);
  assign done = req & ack & last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req <= 1'b0;
      idx <= '0;
    end else if (start) begin
      req <= 1'b1;
      idx <= '0;
    end else if (req && ack) begin
      // Index never wraps here; it only returns to 0 on the next start.
      if (last) req <= 1'b0;
      else      idx <= idx + IDX_W'(1);
    end
  end
endmodule

// File: rtl/ga_generation_controller.sv
// Generation sequencer: init, evaluate every individual, check stop rules, breed every slot,
// while tracking the best fitness and the index that produced it.
module ga_generation_controller
  import ga_pkg::*;
#(
  parameter int POP_SIZE = GA_POP_SIZE,
  parameter int MAX_GEN  = GA_MAX_GEN,
  parameter int FIT_W    = GA_FIT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  ga_generation_controller_if.master  bus,
  output ga_state_t                   state_dbg
);
  localparam int IDX_W = idx_width(POP_SIZE);
  localparam int GEN_W = gen_width(MAX_GEN);
  localparam logic [GEN_W-1:0] LAST_GEN = GEN_W'(MAX_GEN - 1);

  ga_state_t        state, state_nxt;
  logic             start_init, start_eval, start_breed;
  logic             init_req, init_done, init_last;
  logic [0:0]       init_idx;
  logic             fit_req, fit_done, fit_last, fit_xfer;
  logic             breed_req, breed_done, breed_last;
  logic [IDX_W-1:0] fit_idx, breed_idx;
  logic [FIT_W-1:0] target_q, best_fit_q;
  logic [IDX_W-1:0] best_idx_q;
  logic [GEN_W-1:0] gen_q;
  logic             busy_q, done_q;
  logic             unused_iter;

  ga_req_iter #(.COUNT(1), .IDX_W(1)) u_init_iter (
    .clk(clk), .reset(reset), .start(start_init), .ack(bus.init_ack),
    .req(init_req), .idx(init_idx), .last(init_last), .done(init_done)
  );

  ga_req_iter #(.COUNT(POP_SIZE), .IDX_W(IDX_W)) u_fit_iter (
    .clk(clk), .reset(reset), .start(start_eval), .ack(bus.fit_ack),
    .req(fit_req), .idx(fit_idx), .last(fit_last), .done(fit_done)
  );

  ga_req_iter #(.COUNT(POP_SIZE), .IDX_W(IDX_W)) u_breed_iter (
    .clk(clk), .reset(reset), .start(start_breed), .ack(bus.breed_ack),
    .req(breed_req), .idx(breed_idx), .last(breed_last), .done(breed_done)
  );

  assign unused_iter = ^{init_idx, init_last, fit_last, breed_last};
  assign fit_xfer    = fit_req & bus.fit_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Iterator starts fire on the entering edge so each REQ is high on the state's first cycle.
  always_comb begin
    state_nxt   = state;
    start_init  = 1'b0;
    start_eval  = 1'b0;
    start_breed = 1'b0;
    unique case (state)
      S_IDLE:   if (bus.start) begin state_nxt = S_INIT; start_init = 1'b1; end
      S_INIT:   if (init_done) begin state_nxt = S_EVAL; start_eval = 1'b1; end
      S_EVAL:   if (fit_done) state_nxt = S_CHECK;
      S_CHECK: begin
        if (best_fit_q >= target_q || gen_q == LAST_GEN) begin
          state_nxt = S_FINISH;
        end else begin
          state_nxt   = S_BREED;
          start_breed = 1'b1;
        end
      end
      S_BREED:  if (breed_done) begin state_nxt = S_EVAL; start_eval = 1'b1; end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      target_q   <= '0;
      best_fit_q <= '0;
      best_idx_q <= '0;
      gen_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      busy_q <= (state_nxt != S_IDLE);
      done_q <= (state_nxt == S_FINISH);
      if (start_init) begin
        target_q   <= bus.target_fit;
        best_fit_q <= '0;
        best_idx_q <= '0;
        gen_q      <= '0;
      end else begin
        // Strict compare: a tie leaves the earlier holder in place.
        if (fit_xfer && bus.fit_value > best_fit_q) begin
          best_fit_q <= bus.fit_value;
          best_idx_q <= fit_idx;
        end
        if (breed_done) gen_q <= gen_q + GEN_W'(1);
      end
    end
  end

  assign bus.init_req  = init_req;
  assign bus.fit_req   = fit_req;
  assign bus.fit_idx   = fit_idx;
  assign bus.breed_req = breed_req;
  assign bus.breed_idx = breed_idx;
  assign bus.gen_count = gen_q;
  assign bus.best_fit  = best_fit_q;
  assign bus.best_idx  = best_idx_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign state_dbg     = state;
endmodule

// File: tb/tb_ga_generation_controller.sv
// Bench for ga_generation_controller: vector table, directed corner sequences and random runs
// compared against a generation-level model of the algorithm flow.
module tb_ga_generation_controller;
  import ga_pkg::*;

  localparam int P     = 4;
  localparam int MG    = 3;
  localparam int FW    = 16;
  localparam int IDX_W = idx_width(P);

  typedef struct {
    logic [FW-1:0]      target;
    logic [3:0][FW-1:0] g0, g1, g2;
    int                 delay;
    int                 exp_best, exp_idx, exp_gens;
  } vec_t;

  logic      clk;
  logic      reset;
  ga_state_t state_dbg;

  ga_generation_controller_if #(.POP_SIZE(P), .MAX_GEN(MG), .FIT_W(FW)) bus ();

  ga_generation_controller #(.POP_SIZE(P), .MAX_GEN(MG), .FIT_W(FW)) dut (
    .clk(clk), .reset(reset), .bus(bus), .state_dbg(state_dbg)
  );

  int            checks, errors;
  logic [63:0]   exp_q[$];
  logic [FW-1:0] tab [MG][P];
  int            ack_delay;
  bit            stray;
  int            i_xfers, f_xfers, b_xfers, idx_bad;
  bit            r [3];
  bit            a [3];
  int            w [3];
  vec_t          vecs [6];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0][FW-1:0] v4(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][FW-1:0] v;
    v[0] = FW'(x0); v[1] = FW'(x1); v[2] = FW'(x2); v[3] = FW'(x3);
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Environment side of the three req/ack links; counts transfers and checks index order.
  initial begin
    bus.init_ack  = 1'b0;
    bus.fit_ack   = 1'b0;
    bus.breed_ack = 1'b0;
    bus.fit_value = '0;
    forever begin
      int gi;
      @(negedge clk);
      if (!reset || !bus.busy) begin
        i_xfers = 0; f_xfers = 0; b_xfers = 0;
      end
      r[0] = bus.init_req; r[1] = bus.fit_req; r[2] = bus.breed_req;
      for (int k = 0; k < 3; k++) begin
        w[k] = r[k] ? w[k] + 1 : 0;
        if (ack_delay == 0)  a[k] = 1'b1;
        else if (r[k])       a[k] = (w[k] >= ack_delay);
        else                 a[k] = stray && ($urandom_range(0, 3) == 0);
      end
      if (r[1] && bus.fit_idx !== IDX_W'(f_xfers % P))   idx_bad++;
      if (r[2] && bus.breed_idx !== IDX_W'(b_xfers % P)) idx_bad++;
      gi = f_xfers / P;
      if (gi > MG - 1) gi = MG - 1;
      bus.fit_value = tab[gi][f_xfers % P];
      bus.init_ack  = a[0];
      bus.fit_ack   = a[1];
      bus.breed_ack = a[2];
      if (r[0] && a[0]) begin i_xfers++; w[0] = 0; end
      if (r[1] && a[1]) begin f_xfers++; w[1] = 0; end
      if (r[2] && a[2]) begin b_xfers++; w[2] = 0; end
    end
  end

  task automatic load_tab(input vec_t v);
    for (int i = 0; i < P; i++) begin
      tab[0][i] = v.g0[i];
      tab[1][i] = v.g1[i];
      tab[2][i] = v.g2[i];
    end
  endtask

  // Reference: evaluate generations in order, strict-greater best, stop on target or last gen.
  function automatic void model(input logic [FW-1:0] target, output int best, output int bidx,
                                output int gens);
    best = 0; bidx = 0; gens = 0;
    for (int g = 0; g < MG; g++) begin
      gens = g + 1;
      for (int i = 0; i < P; i++) begin
        if (int'(tab[g][i]) > best) begin
          best = int'(tab[g][i]);
          bidx = i;
        end
      end
      if (best >= int'(target)) break;
    end
  endfunction

  task automatic check_all_zero(input string name);
    check({name, " reqs"}, {bus.init_req, bus.fit_req, bus.breed_req}, 0);
    check({name, " idxs"}, {bus.fit_idx, bus.breed_idx, bus.best_idx}, 0);
    check({name, " gen_best"}, {bus.gen_count, bus.best_fit}, 0);
    check({name, " busy_done"}, {bus.busy, bus.done}, 0);
    check({name, " state"}, state_dbg, S_IDLE);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      bus.start = 1'b0;
      cyc++;
    end while (!bus.done && cyc < 2000);
  endtask

  task automatic run_case(input string name, input logic [FW-1:0] target, input int dly,
                          input int exp_best, input int exp_idx, input int exp_gens);
    int          cyc, bad0;
    logic [63:0] e;
    ack_delay = dly;
    stray     = (dly != 0);
    bad0      = idx_bad;
    exp_q.push_back({32'(exp_best), 16'(exp_idx), 16'(exp_gens)});
    @(negedge clk);
    bus.target_fit = target;
    bus.start      = 1'b1;
    wait_done(cyc);
    e = exp_q.pop_front();
    check({name, " done"}, bus.done, 1);
    check({name, " best_fit"}, bus.best_fit, e[63:32]);
    check({name, " best_idx"}, bus.best_idx, e[31:16]);
    check({name, " gen_count"}, bus.gen_count, e[15:0] - 1);
    check({name, " busy_in_finish"}, bus.busy, 1);
    check({name, " init_xfers"}, i_xfers, 1);
    check({name, " eval_xfers"}, f_xfers, e[15:0] * P);
    check({name, " breed_xfers"}, b_xfers, (e[15:0] - 1) * P);
    check({name, " idx_order"}, idx_bad, bad0);
    if (dly == 0) check({name, " latency"}, cyc, 3 + P + (e[15:0] - 1) * (2 * P + 1));
    @(negedge clk);
    check({name, " done_pulse"}, bus.done, 0);
    check({name, " idle"}, {bus.busy, state_dbg}, {1'b0, S_IDLE});
    check({name, " best_hold"}, bus.best_fit, e[63:32]);
  endtask

  initial begin
    int n, best, bidx, gens;
    vec_t v;
    reset          = 1'b0;
    bus.start      = 1'b0;
    bus.target_fit = '0;
    ack_delay      = 0;
    stray          = 1'b0;

    vecs[0] = '{16'd100, v4(5, 9, 9, 3), v4(5, 9, 9, 3), v4(5, 9, 9, 3), 0, 9, 1, 3};
    vecs[1] = '{16'd50, v4(10, 60, 70, 5), v4(1, 1, 1, 1), v4(1, 1, 1, 1), 0, 70, 2, 1};
    vecs[2] = '{16'd1, v4(0, 0, 0, 0), v4(0, 0, 0, 0), v4(0, 0, 0, 0), 0, 0, 0, 3};
    vecs[3] = '{16'd9, v4(1, 2, 3, 4), v4(8, 2, 8, 1), v4(0, 0, 9, 0), 3, 9, 2, 3};
    vecs[4] = '{16'd20, v4(3, 3, 3, 3), v4(0, 20, 20, 0), v4(99, 99, 99, 99), 0, 20, 1, 2};
    vecs[5] = '{16'd0, v4(0, 0, 0, 0), v4(7, 7, 7, 7), v4(7, 7, 7, 7), 2, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    @(negedge clk);

    // Reset in the middle of gen 1 evaluation, then a clean run from generation 0.
    load_tab(vecs[0]);
    bus.target_fit = 16'd100;
    bus.start      = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      bus.start = 1'b0;
      n++;
    end while (!(bus.fit_req && bus.gen_count == 1 && bus.fit_idx == 2) && n < 200);
    check("midrun reached", n < 200, 1);
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    @(negedge clk);
    reset = 1'b1;
    run_case("after_reset", vecs[0].target, 0, 9, 1, 3);

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      load_tab(v);
      run_case($sformatf("vec%0d", i), v.target, v.delay, v.exp_best, v.exp_idx, v.exp_gens);
    end

    // START raised during BREED and held: ignored while busy, relaunches one cycle into IDLE.
    load_tab(vecs[0]);
    ack_delay = 0;
    stray     = 1'b0;
    @(negedge clk);
    bus.target_fit = 16'd100;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.breed_req && n < 100) begin @(negedge clk); n++; end
    check("hold breed_seen", bus.breed_req, 1);
    bus.start = 1'b1;
    n = 0;
    while (!bus.done && n < 200) begin @(negedge clk); n++; end
    check("hold done", bus.done, 1);
    check("hold gen_count", bus.gen_count, 2);
    check("hold best", {bus.best_fit, bus.best_idx}, {16'd9, 2'd1});
    @(negedge clk);
    check("hold idle", {bus.busy, state_dbg}, {1'b0, S_IDLE});
    @(negedge clk);
    check("hold relaunch", {bus.busy, bus.init_req, bus.gen_count, bus.best_fit}, {2'b11, 2'd0, 16'd0});
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 200) begin @(negedge clk); n++; end
    check("hold rerun", {bus.done, bus.gen_count, bus.best_fit}, {1'b1, 2'd2, 16'd9});
    @(negedge clk);

    // Random runs against the generation-level model; small value range forces ties.
    for (int t = 0; t < 8; t++) begin
      logic [FW-1:0] tgt;
      int dly;
      for (int g = 0; g < MG; g++)
        for (int i = 0; i < P; i++) tab[g][i] = FW'($urandom_range(0, 15));
      tgt = FW'($urandom_range(0, 18));
      dly = $urandom_range(0, 3);
      model(tgt, best, bidx, gens);
      run_case($sformatf("rand%0d", t), tgt, dly, best, bidx, gens);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
